// File: rtl/mem_arb_pkg.sv
// Shared types for the data memory arbiter: request bundle and read-return owner tags.
// Default widths match data_Mem's 32-bit address/data buses.
package mem_arb_pkg;

    localparam int AW_DEF = 32;
    localparam int DW_DEF = 32;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } owner_t;

    typedef struct packed {
        logic [AW_DEF-1:0] addr;
        logic [DW_DEF-1:0] wdata;
        logic              we;
        logic              is_byte;
    } mem_req_t;

    // Tag pushed into the return pipe for a granted access.
    function automatic owner_t rd_tag(
        input logic g0,
        input logic g1,
        input logic we0,
        input logic we1
    );
        owner_t t;
        t = OWN_NONE;
        if (g0 && !we0) t = OWN_P0;
        if (g1 && !we1) t = OWN_P1;
        return t;
    endfunction

endpackage

// File: rtl/rd_return_pipe.sv
// Owner-tag delay line: a tag pushed on a grant edge reaches the tail
// exactly when data_Mem presents the read data (RD_LAT cycles after mem_re).
module rd_return_pipe
    import mem_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic   clk,
    input  logic   rst_n,
    input  owner_t push,
    output owner_t tail
);

    owner_t stage [RD_LAT+1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= RD_LAT; i++) begin
                stage[i] <= OWN_NONE;
            end
        end else begin
            stage[0] <= push;
            for (int i = 1; i <= RD_LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tail = stage[RD_LAT];

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter/sequencer in front of data_Mem: MEM stage (port 0, priority)
// and loader/debug (port 1, starvation-protected), one registered command per cycle.
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW           = AW_DEF,
    parameter int DW           = DW_DEF,
    parameter int STARVE_LIMIT = 4,
    parameter int RD_LAT       = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          byte0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    input  logic          byte1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          stall0,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_re,
    output logic          mem_we,
    output logic          mem_isByte,
    input  logic [DW-1:0] mem_rdata
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("data_mem_arbiter: STARVE_LIMIT must be >= 1");
    end
    if (RD_LAT < 0 || RD_LAT > 3) begin : g_bad_lat
        $error("data_mem_arbiter: RD_LAT must be 0..3");
    end
    if (AW != AW_DEF || DW != DW_DEF) begin : g_bad_width
        $error("data_mem_arbiter: AW/DW must match mem_req_t widths");
    end

    mem_req_t        r0;
    mem_req_t        r1;
    mem_req_t        sel;
    logic [SW-1:0]   starve_cnt;
    logic            force1;
    owner_t          push_tag;
    owner_t          tail_tag;

    always_comb begin
        r0         = '0;
        r0.addr    = AW_DEF'(addr0);
        r0.wdata   = DW_DEF'(wdata0);
        r0.we      = we0;
        r0.is_byte = byte0;
        r1         = '0;
        r1.addr    = AW_DEF'(addr1);
        r1.wdata   = DW_DEF'(wdata1);
        r1.we      = we1;
        r1.is_byte = byte1;
    end

    assign force1 = (starve_cnt == SW'(STARVE_LIMIT));

    // Port 0 wins unless port 1 has been denied STARVE_LIMIT cycles in a row.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (force1 && req1) begin
            gnt1 = 1'b1;
        end else if (req0) begin
            gnt0 = 1'b1;
        end else if (req1) begin
            gnt1 = 1'b1;
        end
    end

    assign stall0 = req0 & ~gnt0;
    assign sel    = gnt1 ? r1 : r0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!req1 || gnt1) begin
            starve_cnt <= '0;
        end else if (!force1) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // Address/data hold their last value on idle cycles; only strobes drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_isByte <= 1'b0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
        end else begin
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            if (gnt0 || gnt1) begin
                mem_addr   <= AW'(sel.addr);
                mem_wdata  <= DW'(sel.wdata);
                mem_isByte <= sel.is_byte;
                mem_re     <= ~sel.we;
                mem_we     <= sel.we;
            end
        end
    end

    assign push_tag = rd_tag(gnt0, gnt1, we0, we1);

    rd_return_pipe #(
        .RD_LAT (RD_LAT)
    ) u_ret (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_tag),
        .tail  (tail_tag)
    );

    assign rvalid0 = (tail_tag == OWN_P0);
    assign rvalid1 = (tail_tag == OWN_P1);
    assign rdata0  = rvalid0 ? mem_rdata : '0;
    assign rdata1  = rvalid1 ? mem_rdata : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: data_Mem stand-in, grant/return reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_data_mem_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LIMIT = 4;
    localparam int LAT   = 1;

    logic          clk;
    logic          rst_n;
    logic          req0, we0, byte0;
    logic          req1, we1, byte1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, stall0;
    logic          rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_re, mem_we, mem_isByte;
    logic [DW-1:0] mem_rdata;

    int errors;
    int checks;
    int cyc;

    data_mem_arbiter #(
        .AW           (AW),
        .DW           (DW),
        .STARVE_LIMIT (LIMIT),
        .RD_LAT       (LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0       (req0),
        .we0        (we0),
        .addr0      (addr0),
        .wdata0     (wdata0),
        .byte0      (byte0),
        .req1       (req1),
        .we1        (we1),
        .addr1      (addr1),
        .wdata1     (wdata1),
        .byte1      (byte1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .stall0     (stall0),
        .rvalid0    (rvalid0),
        .rvalid1    (rvalid1),
        .rdata0     (rdata0),
        .rdata1     (rdata1),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_isByte (mem_isByte),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    // data_Mem stand-in: write on the edge ending the mem_we cycle,
    // registered read data one cycle after mem_re.
    logic [31:0] env_mem [256];
    initial begin
        for (int i = 0; i < 256; i++) env_mem[i] = '0;
        env_mem[8]  = 32'h11;
        env_mem[12] = 32'h22;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            if (mem_re) mem_rdata <= env_mem[mem_addr[7:0]];
            if (mem_we)
                env_mem[mem_addr[7:0]] = mem_isByte ?
                    {24'h0, mem_wdata[7:0]} : mem_wdata;
        end
    end

    // Reference model: grant rules, expected command, scheduled returns.
    logic [31:0] ref_mem [256];
    int          m_starve;
    logic        m_re, m_we, m_byte;
    logic [31:0] m_addr, m_wdata;
    logic [1:0]  slot_own [8];
    logic [31:0] slot_dat [8];

    task automatic model_reset();
        m_starve = 0;
        m_re = 0; m_we = 0; m_byte = 0;
        m_addr = '0; m_wdata = '0;
        for (int i = 0; i < 8; i++) begin
            slot_own[i] = 2'd0;
            slot_dat[i] = '0;
        end
    endtask

    initial begin
        logic        e_g0, e_g1, e_rv0, e_rv1, s_we, s_byte;
        logic [31:0] s_addr, s_wdata;
        int          k, due;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        ref_mem[8]  = 32'h11;
        ref_mem[12] = 32'h22;
        model_reset();
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) model_reset();
            e_g1 = req1 && (m_starve == LIMIT || !req0);
            e_g0 = req0 && !e_g1;
            k = cyc % 8;
            e_rv0 = (slot_own[k] == 2'd1);
            e_rv1 = (slot_own[k] == 2'd2);
            cmp("gnt0", 32'(gnt0), 32'(e_g0));
            cmp("gnt1", 32'(gnt1), 32'(e_g1));
            cmp("stall0", 32'(stall0), 32'(req0 && !e_g0));
            cmp("mem_re", 32'(mem_re), 32'(m_re));
            cmp("mem_we", 32'(mem_we), 32'(m_we));
            if (m_re || m_we) begin
                cmp("mem_addr", mem_addr, m_addr);
                cmp("mem_isByte", 32'(mem_isByte), 32'(m_byte));
            end
            if (m_we) cmp("mem_wdata", mem_wdata, m_wdata);
            cmp("rvalid0", 32'(rvalid0), 32'(e_rv0));
            cmp("rvalid1", 32'(rvalid1), 32'(e_rv1));
            cmp("rdata0", rdata0, e_rv0 ? slot_dat[k] : 32'h0);
            cmp("rdata1", rdata1, e_rv1 ? slot_dat[k] : 32'h0);
            slot_own[k] = 2'd0;
            if (rst_n) begin
                m_re = 0;
                m_we = 0;
                if (e_g0 || e_g1) begin
                    s_addr  = e_g1 ? addr1 : addr0;
                    s_wdata = e_g1 ? wdata1 : wdata0;
                    s_we    = e_g1 ? we1 : we0;
                    s_byte  = e_g1 ? byte1 : byte0;
                    m_addr = s_addr; m_wdata = s_wdata; m_byte = s_byte;
                    m_re = !s_we; m_we = s_we;
                    if (s_we) begin
                        ref_mem[s_addr[7:0]] = s_byte ?
                            {24'h0, s_wdata[7:0]} : s_wdata;
                    end else begin
                        due = (cyc + 1 + LAT) % 8;
                        slot_own[due] = e_g1 ? 2'd2 : 2'd1;
                        slot_dat[due] = ref_mem[s_addr[7:0]];
                    end
                end
                if (req1 && !e_g1)
                    m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
                else
                    m_starve = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0 = 0; we0 = 0; byte0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; byte1 = 0; addr1 = '0; wdata1 = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, n1;
        errors = 0;
        checks = 0;
        rst_n = 0;
        idle();
        tick(); tick();
        rst_n = 1;

        // 1: idle after reset
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cmp("t1_re_we", 32'({mem_re, mem_we}), 32'h0);
            cmp("t1_rv", 32'({rvalid0, rvalid1}), 32'h0);
            cmp("t1_gnt", 32'({gnt0, gnt1}), 32'h0);
            tick();
        end

        // 2: P0 write 0xAB @4 then read @4
        req0 = 1; we0 = 1; addr0 = 32'd4; wdata0 = 32'hAB;
        @(negedge clk);
        cmp("t2_gnt0_w", 32'(gnt0), 32'h1);
        tick();
        we0 = 0; wdata0 = '0;
        @(negedge clk);
        cmp("t2_gnt0_r", 32'(gnt0), 32'h1);
        cmp("t2_mem_we", 32'(mem_we), 32'h1);
        tick();
        idle();
        @(negedge clk);
        cmp("t2_mem_re", 32'(mem_re), 32'h1);
        cmp("t2_mem_addr", mem_addr, 32'd4);
        tick();
        @(negedge clk);
        cmp("t2_rvalid0", 32'(rvalid0), 32'h1);
        cmp("t2_rdata0", rdata0, 32'hAB);
        tick(); tick();

        // 3: both ports held high
        req0 = 1; addr0 = 32'd16;
        req1 = 1; addr1 = 32'd20;
        n0 = 0; n1 = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cmp("t3_gnt1", 32'(gnt1), 32'(i % 5 == 4));
            cmp("t3_stall0", 32'(stall0), 32'(i % 5 == 4));
            n0 += int'(gnt0);
            n1 += int'(gnt1);
            tick();
        end
        cmp("t3_n0", 32'(n0), 32'd8);
        cmp("t3_n1", 32'(n1), 32'd2);
        idle();
        tick(); tick(); tick();

        // 4: P1 back-to-back reads @8, @12
        req1 = 1; addr1 = 32'd8;
        @(negedge clk);
        cmp("t4_gnt1_a", 32'(gnt1), 32'h1);
        tick();
        addr1 = 32'd12;
        @(negedge clk);
        cmp("t4_gnt1_b", 32'(gnt1), 32'h1);
        tick();
        idle();
        @(negedge clk);
        cmp("t4_rv1_a", 32'(rvalid1), 32'h1);
        cmp("t4_rd1_a", rdata1, 32'h11);
        tick();
        @(negedge clk);
        cmp("t4_rv1_b", 32'(rvalid1), 32'h1);
        cmp("t4_rd1_b", rdata1, 32'h22);
        cmp("t4_rv0", 32'(rvalid0), 32'h0);
        tick(); tick();

        // 5: P1 byte write 0x5A @3
        req1 = 1; we1 = 1; byte1 = 1; addr1 = 32'd3; wdata1 = 32'h5A;
        tick();
        idle();
        @(negedge clk);
        cmp("t5_isByte", 32'(mem_isByte), 32'h1);
        cmp("t5_addr", mem_addr, 32'd3);
        cmp("t5_wdata", mem_wdata, 32'h5A);
        tick(); tick();

        // 6: reset one cycle after a P0 read grant
        req0 = 1; addr0 = 32'd4;
        tick();
        idle();
        rst_n = 0;
        #1;
        cmp("t6_re_in_rst", 32'(mem_re), 32'h0);
        tick();
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cmp("t6_no_rv0", 32'(rvalid0), 32'h0);
            tick();
        end
        req0 = 1; addr0 = 32'd4;
        @(negedge clk);
        cmp("t6_gnt0", 32'(gnt0), 32'h1);
        tick();
        idle();
        tick();
        @(negedge clk);
        cmp("t6_rvalid0", 32'(rvalid0), 32'h1);
        cmp("t6_rdata0", rdata0, 32'hAB);
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
